// File: rtl/smc_pkg.sv
// Shared constants, FSM state encoding and mode encodings for the SMC frame loader.
// The optional range check is enabled by defining SMC_RANGE_CHECK_EN.
package smc_pkg;

    localparam int NUM_FET = 6;
    localparam int DW      = 3;
    localparam int MW      = 2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,
        MODE_1 = 2'd1,
        MODE_2 = 2'd2,
        MODE_3 = 2'd3
    } smc_mode_e;

    // Width of a beat counter able to index n slots (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/smc_param_bank.sv
// Shadow/output register bank: per-slot write enables fill the shadow bank, and a commit
// strobe copies the whole shadow (plus any same-cycle write) to the output bank at once.
module smc_param_bank #(
    parameter int NUM_FET = smc_pkg::NUM_FET,
    parameter int TW      = 3 * smc_pkg::DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FET-1:0]    wr_en,
    input  logic [TW-1:0]         wr_data,
    input  logic                  commit,
    output logic [NUM_FET*TW-1:0] out_params
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FET; gi++) begin : g_slot
            logic [TW-1:0] shadow_q;
            logic [TW-1:0] out_q;

            // The last beat is written on the commit edge itself, so bypass it into the output.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q <= '0;
                    out_q    <= '0;
                end else begin
                    if (wr_en[gi]) shadow_q <= wr_data;
                    if (commit)    out_q    <= wr_en[gi] ? wr_data : shadow_q;
                end
            end

            assign out_params[gi*TW +: TW] = out_q;
        end
    endgenerate

endmodule

// File: rtl/smc_frame_loader.sv
// Collects NUM_FET serial (W, V_GS, V_DS) beats into a frame and presents it to the SMC as a
// stable parallel bus. Define SMC_RANGE_CHECK_EN to build the zero-W / zero-V_GS error flag.
module smc_frame_loader #(
    parameter int NUM_FET = smc_pkg::NUM_FET,
    parameter int DW      = smc_pkg::DW,
    parameter int MW      = smc_pkg::MW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [MW-1:0]           in_mode,
    input  logic [DW-1:0]           in_w,
    input  logic [DW-1:0]           in_vgs,
    input  logic [DW-1:0]           in_vds,
    output logic [NUM_FET*3*DW-1:0] out_params,
    output logic [MW-1:0]           out_mode,
    output logic                    out_valid,
    output logic                    out_abort,
    output logic                    out_err,
    output logic                    busy
);

    import smc_pkg::*;

    localparam int CW = cnt_width(NUM_FET);
    localparam int TW = 3 * DW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_FET - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   slot;
    logic [NUM_FET-1:0] wr_en;
    logic            commit;
    logic            abort;
    logic [MW-1:0]   mode_q;
    logic [MW-1:0]   out_mode_q;
    logic            out_valid_q;
    logic            out_abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_COLLECT;
                    cnt_d   = CW'(1);
                end
            end
            ST_COLLECT: begin
                if (!in_valid || cnt_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        slot   = (state_q == ST_COLLECT) ? cnt_q : '0;
        commit = (state_q == ST_COLLECT) && in_valid && (cnt_q == LAST_BEAT);
        abort  = (state_q == ST_COLLECT) && !in_valid;
        busy   = (state_q == ST_COLLECT);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FET; gi++) begin : g_wr_en
            assign wr_en[gi] = in_valid && (slot == CW'(gi));
        end
    endgenerate

    smc_param_bank #(
        .NUM_FET (NUM_FET),
        .TW      (TW)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    ({in_w, in_vgs, in_vds}),
        .commit     (commit),
        .out_params (out_params)
    );

    // Mode is only meaningful on beat 0; later beats may carry anything on in_mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            out_mode_q  <= '0;
            out_valid_q <= 1'b0;
            out_abort_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_valid) mode_q <= in_mode;
            if (commit) out_mode_q <= mode_q;
            out_valid_q <= commit;
            out_abort_q <= abort;
        end
    end

    assign out_mode  = out_mode_q;
    assign out_valid = out_valid_q;
    assign out_abort = out_abort_q;

`ifdef SMC_RANGE_CHECK_EN
    logic beat_bad;
    logic err_q;
    logic out_err_q;

    assign beat_bad = (in_w == '0) || (in_vgs == '0);

    // Beat 0 restarts the accumulated flag so a back-to-back frame starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            if (in_valid) err_q <= (state_q == ST_IDLE) ? beat_bad : (err_q | beat_bad);
            out_err_q <= commit && (err_q || beat_bad);
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_smc_frame_loader.sv
// Directed bench for smc_frame_loader: expected frames are queued when driven and
// compared by a monitor whenever out_valid pulses.
module tb_smc_frame_loader;

    localparam int NF = 6;
    localparam int DW = 3;
    localparam int MW = 2;
    localparam int TW = 3 * DW;
    localparam int PW = NF * TW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [MW-1:0] in_mode = '0;
    logic [DW-1:0] in_w = '0;
    logic [DW-1:0] in_vgs = '0;
    logic [DW-1:0] in_vds = '0;
    logic [PW-1:0] out_params;
    logic [MW-1:0] out_mode;
    logic          out_valid;
    logic          out_abort;
    logic          out_err;
    logic          busy;

    smc_frame_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_mode    (in_mode),
        .in_w       (in_w),
        .in_vgs     (in_vgs),
        .in_vds     (in_vds),
        .out_params (out_params),
        .out_mode   (out_mode),
        .out_valid  (out_valid),
        .out_abort  (out_abort),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] params;
        logic [MW-1:0] mode;
        logic          err;
    } frame_t;

    frame_t        exp_q[$];
    frame_t        mon_f;
    int            n_pass = 0;
    int            n_total = 0;
    int            valid_seen = 0;
    int            abort_seen = 0;
    logic [PW-1:0] last_params = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_abort) abort_seen++;
            if (out_valid) begin
                valid_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    mon_f = exp_q.pop_front();
                    $display("commit #%0d: params=%0h mode=%0d err=%0b", valid_seen, out_params, out_mode, out_err);
                    check("frame_params", 64'(out_params), 64'(mon_f.params));
                    check("frame_mode",   64'(out_mode),   64'(mon_f.mode));
                    check("frame_err",    64'(out_err),    64'(mon_f.err));
                end
            end
        end
    end

    task automatic beat(input logic v, input logic [MW-1:0] m, input logic [DW-1:0] w, input logic [DW-1:0] g,
                        input logic [DW-1:0] d);
        in_valid = v;
        in_mode  = m;
        in_w     = w;
        in_vgs   = g;
        in_vds   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, '0, '0, '0, '0);
    endtask

    function automatic logic [PW-1:0] rand_frame();
        logic [PW-1:0] f;
        f = '0;
        for (int k = 0; k < NF; k++)
            f[k*TW +: TW] = {3'($urandom_range(1, 7)), 3'($urandom_range(1, 7)), 3'($urandom_range(0, 7))};
        return f;
    endfunction

    // Drives six contiguous beats; in_mode carries a decoy on beats 1..5.
    task automatic send_frame(input string tag, input logic [MW-1:0] m, input logic [PW-1:0] data);
        logic [TW-1:0] t;
        logic          bad;
        frame_t        f;
        bad = 1'b0;
        for (int k = 0; k < NF; k++) begin
            t = data[k*TW +: TW];
            if (t[8:6] == '0 || t[5:3] == '0) bad = 1'b1;
        end
        f.params = data;
        f.mode   = m;
`ifdef SMC_RANGE_CHECK_EN
        f.err = bad;
`else
        f.err = 1'b0;
`endif
        exp_q.push_back(f);
        for (int k = 0; k < NF; k++) begin
            t = data[k*TW +: TW];
            beat(1'b1, (k == 0) ? m : ~m, t[8:6], t[5:3], t[2:0]);
            check($sformatf("%s_valid_b%0d", tag, k), 64'(out_valid), 64'(k == NF - 1));
            check($sformatf("%s_busy_b%0d", tag, k),  64'(busy),      64'(k != NF - 1));
        end
        last_params = data;
    endtask

    logic [PW-1:0] d_a, d_b, d_d, d_e, d_f;
    logic [2:0]    aw[6]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [2:0]    avgs[6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0]    avds[6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [TW-1:0] t;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d_a = '0;
        for (int k = 0; k < NF; k++) d_a[k*TW +: TW] = {aw[k], avgs[k], avds[k]};
        d_b = rand_frame();
        d_d = rand_frame();
        d_e = rand_frame();
        d_e[2*TW + 6 +: 3] = 3'd0;
        d_f = rand_frame();

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  64'(out_valid),  64'd0);
        check("rst_abort",  64'(out_abort),  64'd0);
        check("rst_err",    64'(out_err),    64'd0);
        check("rst_busy",   64'(busy),       64'd0);
        check("rst_mode",   64'(out_mode),   64'd0);
        check("rst_params", 64'(out_params), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            idle(1);
            check($sformatf("idle_quiet_%0d", i), 64'({out_valid, out_abort, busy}), 64'd0);
        end

        send_frame("A", 2'd2, d_a);
        send_frame("B", 2'd1, d_b);
        idle(1);
        check("B_valid_after", 64'(out_valid), 64'd0);
        check("B_mode",        64'(out_mode),  64'd1);
        check("ab_count",      64'(valid_seen), 64'd2);

        for (int k = 0; k < 3; k++) begin
            t = d_d[k*TW +: TW];
            beat(1'b1, 2'd3, t[8:6], t[5:3], t[2:0]);
        end
        idle(1);
        check("abort_pulse", 64'(out_abort), 64'd1);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy",  64'(busy),      64'd0);
        idle(1);
        check("abort_once",   64'(out_abort),  64'd0);
        check("abort_params", 64'(out_params), 64'(last_params));
        check("abort_mode",   64'(out_mode),   64'd1);
        check("abort_count",  64'(abort_seen), 64'd1);
        check("abort_nocommit", 64'(valid_seen), 64'd2);

        for (int k = 0; k < 4; k++) begin
            t = d_a[k*TW +: TW];
            beat(1'b1, 2'd3, t[8:6], t[5:3], t[2:0]);
        end
        t = d_a[4*TW +: TW];
        in_valid = 1'b1; in_w = t[8:6]; in_vgs = t[5:3]; in_vds = t[2:0];
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_params", 64'(out_params), 64'd0);
        check("mrst_mode",   64'(out_mode),   64'd0);
        check("mrst_busy",   64'(busy),       64'd0);
        check("mrst_valid",  64'({out_valid, out_abort, out_err}), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        check("mrst_no_pulse", 64'({28'(valid_seen), 28'(abort_seen)}), 64'({28'd2, 28'd1}));

        send_frame("D", 2'd3, d_d);
        idle(1);
        send_frame("E", 2'd0, d_e);
        send_frame("F", 2'd2, d_f);
        idle(2);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("valid_count", 64'(valid_seen),   64'd5);
        check("abort_final", 64'(abort_seen),   64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
